fault_latch_ctrl: RTL and testbench

//  Controller for sticky fault capture: arms/disarms capture, latches masked fault bits high until

---
 rtl/fault_latch_ctrl.sv | 142 ++++++++++++++
 tb/tb_fault_latch_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_latch_ctrl.sv
// rtl/fault_latch_ctrl.sv - sticky fault capture controller with first-fault record, event counter and irq
// Latches armed, masked fault bits until software clears them through a valid/ready request.
module fault_latch_ctrl #(
  parameter int WIDTH     = 32,
  parameter int TS_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 arm,
  input  logic [WIDTH-1:0]     fault_mask,
  input  logic [WIDTH-1:0]     irq_mask,
  input  logic [WIDTH-1:0]     din,
  input  logic                 clr_valid,
  input  logic [WIDTH-1:0]     clr_bits,
  input  logic                 clr_count,
  output logic                 clr_ready,
  output logic [WIDTH-1:0]     status,
  output logic [WIDTH-1:0]     first_fault,
  output logic [TS_WIDTH-1:0]  first_ts,
  output logic                 first_valid,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic                 irq,
  output logic                 tripped
);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_TRIPPED  = 2'd2,
    S_CLEARING = 2'd3
  } state_t;

  localparam logic [TS_WIDTH-1:0]  TS_ONE  = {{(TS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t              state;
  logic [TS_WIDTH-1:0] ts;
  logic [WIDTH-1:0]    sticky;
  logic [WIDTH-1:0]    live;
  logic [WIDTH-1:0]    new_bits;
  logic [WIDTH-1:0]    clear_applied;
  logic [WIDTH-1:0]    sticky_nxt;
  logic                accept;
  logic                count_clear;

  always_comb begin
    live          = din & fault_mask & {WIDTH{arm}};
    accept        = clr_valid & clr_ready;
    clear_applied = accept ? clr_bits : '0;
    count_clear   = accept & clr_count;
    // Set wins over clear: a bit that is live this cycle survives its own clear.
    sticky_nxt    = (sticky & ~clear_applied) | live;
    new_bits      = live & ~sticky;
    status        = sticky | live;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_DISARMED;
      ts          <= '0;
      sticky      <= '0;
      irq         <= 1'b0;
      event_count <= '0;
      first_fault <= '0;
      first_ts    <= '0;
      first_valid <= 1'b0;
      clr_ready   <= 1'b0;
      tripped     <= 1'b0;
    end else begin
      ts     <= ts + TS_ONE;
      sticky <= sticky_nxt;
      irq    <= |(sticky & irq_mask);

      if (count_clear) begin
        event_count <= '0;
      end else if ((|new_bits) && (event_count != CNT_MAX)) begin
        event_count <= event_count + CNT_ONE;
      end

      // A record is taken only on the arming trip and never overwritten until software drops it.
      if (count_clear) begin
        first_fault <= '0;
        first_ts    <= '0;
        first_valid <= 1'b0;
      end else if (state == S_ARMED && arm && (|live) && !first_valid) begin
        first_fault <= live;
        first_ts    <= ts;
        first_valid <= 1'b1;
      end

      clr_ready <= 1'b1;
      case (state)
        S_DISARMED: begin
          tripped <= 1'b0;
          if (arm) state <= S_ARMED;
        end
        S_ARMED: begin
          if (!arm) begin
            state   <= S_DISARMED;
            tripped <= 1'b0;
          end else if (|live) begin
            state   <= S_TRIPPED;
            tripped <= 1'b1;
          end else begin
            tripped <= 1'b0;
          end
        end
        S_TRIPPED: begin
          if (!arm) begin
            state   <= S_DISARMED;
            tripped <= 1'b0;
          end else if (accept) begin
            state     <= S_CLEARING;
            tripped   <= 1'b1;
            clr_ready <= 1'b0;
          end else begin
            tripped <= 1'b1;
          end
        end
        S_CLEARING: begin
          if (|sticky_nxt) begin
            state   <= S_TRIPPED;
            tripped <= 1'b1;
          end else if (arm) begin
            state   <= S_ARMED;
            tripped <= 1'b0;
          end else begin
            state   <= S_DISARMED;
            tripped <= 1'b0;
          end
        end
        default: begin
          state   <= S_DISARMED;
          tripped <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fault_latch_ctrl.sv
// tb/tb_fault_latch_ctrl.sv - directed self-checking bench for fault_latch_ctrl
module tb_fault_latch_ctrl;

  localparam int WIDTH     = 32;
  localparam int TS_WIDTH  = 32;
  localparam int CNT_WIDTH = 2;

  logic                 clk;
  logic                 resetn;
  logic                 arm;
  logic [WIDTH-1:0]     fault_mask;
  logic [WIDTH-1:0]     irq_mask;
  logic [WIDTH-1:0]     din;
  logic                 clr_valid;
  logic [WIDTH-1:0]     clr_bits;
  logic                 clr_count;
  logic                 clr_ready;
  logic [WIDTH-1:0]     status;
  logic [WIDTH-1:0]     first_fault;
  logic [TS_WIDTH-1:0]  first_ts;
  logic                 first_valid;
  logic [CNT_WIDTH-1:0] event_count;
  logic                 irq;
  logic                 tripped;

  int unsigned cyc;
  int          n_checks;
  int          n_fail;
  int unsigned rec_ts;

  fault_latch_ctrl #(
    .WIDTH(WIDTH),
    .TS_WIDTH(TS_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .arm(arm),
    .fault_mask(fault_mask),
    .irq_mask(irq_mask),
    .din(din),
    .clr_valid(clr_valid),
    .clr_bits(clr_bits),
    .clr_count(clr_count),
    .clr_ready(clr_ready),
    .status(status),
    .first_fault(first_fault),
    .first_ts(first_ts),
    .first_valid(first_valid),
    .event_count(event_count),
    .irq(irq),
    .tripped(tripped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: the DUT timestamp must equal this in every cycle.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    resetn     = 1'b0;
    arm        = 1'b0;
    fault_mask = '0;
    irq_mask   = '0;
    din        = '0;
    clr_valid  = 1'b0;
    clr_bits   = '0;
    clr_count  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_status", status, 0);
    check("rst_clr_ready", clr_ready, 0);
    check("rst_tripped", tripped, 0);
    check("rst_irq", irq, 0);
    check("rst_event_count", event_count, 0);
    check("rst_first_valid", first_valid, 0);
    resetn = 1'b1;

    // 1: single fault at ts=10
    arm        = 1'b1;
    fault_mask = '1;
    irq_mask   = '1;
    tick();
    check("t1_clr_ready_armed", clr_ready, 1);
    check("t1_not_tripped", tripped, 0);
    for (int i = 0; i < 50 && cyc != 10; i++) tick();
    check("t1_reach_ts10", cyc, 10);
    din = 32'h0000_0004;
    #1;
    check("t1_status_same_cycle", status, 32'h4);
    tick();
    din = '0;
    check("t1_first_fault", first_fault, 32'h4);
    check("t1_first_ts", first_ts, 10);
    check("t1_first_valid", first_valid, 1);
    check("t1_event_count", event_count, 1);
    check("t1_tripped", tripped, 1);
    check("t1_irq_not_yet", irq, 0);
    tick();
    check("t1_irq_two_cycles", irq, 1);
    check("t1_status_sticky", status, 32'h4);

    // 2: bit-selective clear through CLEARING
    din = 32'h2;
    tick();
    din = '0;
    check("t2_status_6", status, 32'h6);
    check("t2_event_count", event_count, 2);
    clr_valid = 1'b1;
    clr_bits  = 32'h2;
    tick();
    clr_valid = 1'b0;
    check("t2_clr_ready_low", clr_ready, 0);
    check("t2_status_after_clr", status, 32'h4);
    check("t2_tripped_clearing", tripped, 1);
    tick();
    check("t2_back_tripped", tripped, 1);
    check("t2_clr_ready_high", clr_ready, 1);
    clr_valid = 1'b1;
    clr_bits  = 32'h4;
    tick();
    clr_valid = 1'b0;
    check("t2_status_clear", status, 0);
    tick();
    check("t2_armed_not_tripped", tripped, 0);
    check("t2_irq_dropped", irq, 0);
    check("t2_first_valid_kept", first_valid, 1);
    check("t2_first_fault_kept", first_fault, 32'h4);

    // 3: set wins over clear of the same bit
    din = 32'h1;
    tick();
    check("t3_tripped", tripped, 1);
    check("t3_no_overwrite", first_fault, 32'h4);
    check("t3_event_count", event_count, 3);
    clr_valid = 1'b1;
    clr_bits  = 32'h1;
    tick();
    clr_valid = 1'b0;
    din       = '0;
    check("t3_clearing_ready", clr_ready, 0);
    check("t3_bit0_kept", status, 32'h1);
    tick();
    check("t3_back_tripped", tripped, 1);
    check("t3_ready_back", clr_ready, 1);

    // 4: counter saturation, then clr_count drops the record
    din = 32'h8;
    tick();
    din = '0;
    check("t4_saturated", event_count, 3);
    clr_valid = 1'b1;
    clr_bits  = '1;
    clr_count = 1'b1;
    tick();
    clr_valid = 1'b0;
    clr_count = 1'b0;
    check("t4_count_zero", event_count, 0);
    check("t4_first_valid_zero", first_valid, 0);
    check("t4_first_fault_zero", first_fault, 0);
    check("t4_first_ts_zero", first_ts, 0);
    tick();
    check("t4_armed", tripped, 0);
    rec_ts = cyc;
    din = 32'h10;
    tick();
    din = '0;
    check("t4_rerecord_fault", first_fault, 32'h10);
    check("t4_rerecord_ts", first_ts, rec_ts);
    check("t4_rerecord_valid", first_valid, 1);
    check("t4_count_one", event_count, 1);

    // 5: arm and mask gating
    clr_valid = 1'b1;
    clr_bits  = 32'h10;
    tick();
    clr_valid = 1'b0;
    tick();
    check("t5_armed", tripped, 0);
    arm = 1'b0;
    tick();
    din = 32'hFF;
    #1;
    check("t5_disarmed_status", status, 0);
    tick();
    check("t5_disarmed_no_trip", tripped, 0);
    arm        = 1'b1;
    fault_mask = 32'h0F;
    irq_mask   = '0;
    #1;
    check("t5_masked_status", status, 32'h0F);
    repeat (3) tick();
    check("t5_irq_masked", irq, 0);
    check("t5_tripped", tripped, 1);
    check("t5_status_hold", status, 32'h0F);
    check("t5_record_kept", first_fault, 32'h10);

    // 6: async reset while tripped with a clear pending
    din       = '0;
    clr_valid = 1'b1;
    clr_bits  = 32'h0F;
    #1;
    resetn = 1'b0;
    #1;
    check("t6_status", status, 0);
    check("t6_tripped", tripped, 0);
    check("t6_clr_ready", clr_ready, 0);
    check("t6_irq", irq, 0);
    check("t6_event_count", event_count, 0);
    check("t6_first_valid", first_valid, 0);
    check("t6_first_fault", first_fault, 0);
    check("t6_first_ts", first_ts, 0);
    tick();
    check("t6_clr_ready_held", clr_ready, 0);
    clr_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
